// File: rtl/pwl_sync_slave.sv
// Piecewise-linear chaotic slave oscillator driven by master x samples, with optional lock detection.
// Define PWL_SYNC_LOCK_EN to compile in the lock counter; otherwise lock_o is tied low.
module pwl_sync_slave #(
    parameter int               Width    = 16,
    parameter logic [Width-1:0] H        = 16'h0052,
    parameter logic [Width-1:0] A        = 16'h1333,
    parameter logic [Width-1:0] Y0       = 16'h0000,
    parameter logic [Width-1:0] Z0       = 16'h0000,
    parameter logic [Width-1:0] THRESH   = 16'h0010,
    parameter int               LOCK_CNT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] xm_i,
    input  logic [Width-1:0] ym_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [Width-1:0] ys_o,
    output logic [Width-1:0] zs_o,
    output logic [Width-1:0] err_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             lock_o
);

    localparam int FRAC = 13;
    localparam logic [Width-1:0] ONE = Width'(1 << FRAC);

    typedef enum logic [1:0] {IDLE, RUN, COMP, OUT} state_t;

    state_t           state_q, state_d;
    logic [Width-1:0] xm_q, ym_q;
    logic [Width-1:0] ys_q, zs_q, err_q;
    logic [Width-1:0] xm_abs, err_next, ys_next, zs_next;

    // Signed A(2,13) multiply, truncating the low fraction bits of the double-width product
    function automatic logic [Width-1:0] fmul(input logic [Width-1:0] a, input logic [Width-1:0] b);
        logic signed [2*Width-1:0] p;
        p = $signed(a) * $signed(b);
        return p[Width+FRAC-1:FRAC];
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start_i overrides every other transition, including a same-edge sample handshake
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN:  if (valid_i) state_d = COMP;
                COMP: state_d = OUT;
                OUT:  if (ready_i) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == RUN);
    assign valid_o = (state_q == OUT);

    // |xm| wraps, so 16'h8000 stays 16'h8000
    always_comb begin
        xm_abs   = xm_q[Width-1] ? ('0 - xm_q) : xm_q;
        err_next = ym_q - ys_q;
        ys_next  = ys_q + fmul(H, zs_q);
        zs_next  = zs_q + fmul(H, xm_abs - ONE - ys_q - fmul(A, zs_q));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            xm_q  <= '0;
            ym_q  <= '0;
            ys_q  <= '0;
            zs_q  <= '0;
            err_q <= '0;
        end else if (start_i) begin
            ys_q <= Y0;
            zs_q <= Z0;
        end else if (state_q == RUN && valid_i) begin
            xm_q <= xm_i;
            ym_q <= ym_i;
        end else if (state_q == COMP) begin
            ys_q  <= ys_next;
            zs_q  <= zs_next;
            err_q <= err_next;
        end
    end

    assign ys_o  = ys_q;
    assign zs_o  = zs_q;
    assign err_o = err_q;

`ifdef PWL_SYNC_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [Width-1:0] err_abs;
    logic             lock_q;

    always_comb begin
        err_abs    = err_next[Width-1] ? ('0 - err_next) : err_next;
        lock_cnt_d = '0;
        if (err_abs <= THRESH) begin
            lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + CNT_W'(1);
        end
    end

    // Lock is judged on the same edge that publishes the new result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else if (start_i) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else if (state_q == COMP) begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= (lock_cnt_d == CNT_MAX);
        end
    end

    assign lock_o = lock_q;
`else
    assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_pwl_sync_slave.sv
// Directed bench for pwl_sync_slave: reset, single step, backpressure, restart collisions and lock.
// Lock expectations follow PWL_SYNC_LOCK_EN (LOCK_CNT=4 when defined, 1 when not).
module tb_pwl_sync_slave;

`ifdef PWL_SYNC_LOCK_EN
    localparam int LOCK_N = 4;
`else
    localparam int LOCK_N = 1;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] xm_i = '0;
    logic [15:0] ym_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] ys_o, zs_o, err_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        lock_o;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_ys, m_zs, m_err;
    int          m_cnt;
    logic        m_lock;

    pwl_sync_slave #(
        .Width(16), .H(16'h0052), .A(16'h1333), .Y0(16'h0000), .Z0(16'h2000),
        .THRESH(16'h0010), .LOCK_CNT(LOCK_N)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .xm_i(xm_i), .ym_i(ym_i),
        .valid_i(valid_i), .ready_o(ready_o), .ys_o(ys_o), .zs_o(zs_o), .err_o(err_o),
        .valid_o(valid_o), .ready_i(ready_i), .lock_o(lock_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] fm(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return 16'(p >>> 13);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_restart();
        m_ys = 16'h0000; m_zs = 16'h2000; m_cnt = 0; m_lock = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] xm, input logic [15:0] ym);
        logic [15:0] absx, abse, ys_n, zs_n;
        absx  = xm[15] ? 16'(16'h0000 - xm) : xm;
        m_err = ym - m_ys;
        ys_n  = m_ys + fm(16'h0052, m_zs);
        zs_n  = m_zs + fm(16'h0052, absx - 16'h2000 - m_ys - fm(16'h1333, m_zs));
        m_ys  = ys_n;
        m_zs  = zs_n;
        abse  = m_err[15] ? 16'(16'h0000 - m_err) : m_err;
        if (abse <= 16'h0010) begin
            if (m_cnt < LOCK_N) m_cnt++;
        end else begin
            m_cnt = 0;
        end
`ifdef PWL_SYNC_LOCK_EN
        m_lock = (m_cnt == LOCK_N);
`else
        m_lock = 1'b0;
`endif
    endtask

    // Present one sample in RUN, then follow it through COMP into OUT (ready_i left low)
    task automatic apply_stimulus(input string tag, input logic [15:0] xm, input logic [15:0] ym);
        xm_i = xm; ym_i = ym; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check_output({tag, "_comp"}, {62'd0, valid_o, ready_o}, 64'd0);
        tick();
        model_step(xm, ym);
        check_output({tag, "_out"}, {13'd0, valid_o, ready_o, lock_o, ys_o, zs_o, err_o},
                     {13'd0, 1'b1, 1'b0, m_lock, m_ys, m_zs, m_err});
    endtask

    task automatic release_out(input string tag);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_output(tag, {62'd0, ready_o, valid_o}, {62'd0, 1'b1, 1'b0});
    endtask

    task automatic do_start(input string tag);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        model_restart();
        check_output(tag, {28'd0, ready_o, valid_o, lock_o, ys_o, zs_o},
                     {28'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h2000});
    endtask

    initial begin
        model_restart();
        #2;
        check_output("reset_outputs", {13'd0, ready_o, valid_o, lock_o, ys_o, zs_o, err_o}, 64'd0);
        tick();
        rst_i = 1'b1;
        tick();
        tick();
        check_output("idle_no_start", {63'd0, ready_o}, 64'd0);

        do_start("start_init");

        // Hand-derived: H*zs = 0x52; H*(-0x1333) = -403030/8192 floors to -50, so zs = 0x1FCE
        apply_stimulus("single_step", 16'h2000, 16'h0100);
        check_output("single_step_ys", {48'd0, ys_o}, 64'h0052);
        check_output("single_step_zs", {48'd0, zs_o}, 64'h1FCE);
        check_output("single_step_err", {48'd0, err_o}, 64'h0100);

        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            xm_i = 16'h1000 + 16'(i);
            ym_i = 16'h0200 + 16'(i);
            tick();
            check_output($sformatf("backpressure_%0d", i),
                         {13'd0, valid_o, ready_o, lock_o, ys_o, zs_o, err_o},
                         {13'd0, 1'b1, 1'b0, 1'b0, 16'h0052, 16'h1FCE, 16'h0100});
        end
        valid_i = 1'b0;
        release_out("backpressure_release");

        start_i = 1'b1; valid_i = 1'b1; xm_i = 16'h3000; ym_i = 16'h0400;
        tick();
        start_i = 1'b0; valid_i = 1'b0;
        model_restart();
        check_output("collision_reinit", {30'd0, ready_o, valid_o, ys_o, zs_o},
                     {30'd0, 1'b1, 1'b0, 16'h0000, 16'h2000});
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("collision_no_valid_%0d", i), {46'd0, valid_o, ready_o, ys_o},
                         {46'd0, 1'b0, 1'b1, 16'h0000});
        end

        // |-1.0| = 1.0 gives the same step as the first sample
        apply_stimulus("abs_neg", 16'hE000, 16'h0000);
        check_output("abs_neg_zs", {48'd0, zs_o}, 64'h1FCE);

        do_start("restart_from_out");

        // |0x8000| wraps to 0x8000: term 0x4CCD, H*term = 196, zs = 0x20C4
        apply_stimulus("abs_min", 16'h8000, 16'h0100);
        check_output("abs_min_zs", {48'd0, zs_o}, 64'h20C4);
        release_out("abs_min_release");

        do_start("lock_restart");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus($sformatf("lock_track_%0d", i), 16'h2000, m_ys);
            release_out($sformatf("lock_track_rel_%0d", i));
        end
`ifdef PWL_SYNC_LOCK_EN
        check_output("lock_set", {63'd0, lock_o}, 64'd1);
`else
        check_output("lock_absent", {63'd0, lock_o}, 64'd0);
`endif
        apply_stimulus("lock_break", 16'h2000, m_ys + 16'h0011);
        check_output("lock_break_lock", {63'd0, lock_o}, 64'd0);
        release_out("lock_break_rel");
        apply_stimulus("thresh_edge", 16'h2000, m_ys - 16'h0010);
        check_output("thresh_edge_err", {48'd0, err_o}, 64'hFFF0);

        #2;
        rst_i = 1'b0;
        #1;
        check_output("async_reset_mid_out", {13'd0, ready_o, valid_o, lock_o, ys_o, zs_o, err_o}, 64'd0);
        tick();
        rst_i = 1'b1;
        tick();
        check_output("post_reset_idle", {62'd0, ready_o, valid_o}, 64'd0);
        do_start("post_reset_start");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
